// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT component widths, Q16 twiddle format and packed complex type
package fft_pkg;
    localparam int DATA_W = 16;
    localparam int TW_W = 20;
    localparam int TW_SHIFT = 16;
    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;
endpackage

// File: rtl/cmul_conj.sv
// cmul_conj: T = B*conj(W) at full precision, rounded half-up at the twiddle binary point
module cmul_conj #(
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int TW_W = fft_pkg::TW_W,
    parameter int SHIFT = fft_pkg::TW_SHIFT
) (
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  logic signed [TW_W-1:0]   w_re,
    input  logic signed [TW_W-1:0]   w_im,
    output logic signed [DATA_W+1:0] t_re,
    output logic signed [DATA_W+1:0] t_im
);
    localparam int PW = DATA_W + TW_W + 1;
    logic signed [PW-1:0] br, bi, wr, wi, p_re, p_im;
    assign br = PW'(b_re);
    assign bi = PW'(b_im);
    assign wr = PW'(w_re);
    assign wi = PW'(w_im);
    assign p_re = br * wr + bi * wi;
    assign p_im = bi * wr - br * wi;
    // keep every operand signed so the shift stays arithmetic
    assign t_re = (DATA_W+2)'((p_re >>> SHIFT) + (p_re[SHIFT-1] ? PW'(1) : PW'(0)));
    assign t_im = (DATA_W+2)'((p_im >>> SHIFT) + (p_im[SHIFT-1] ? PW'(1) : PW'(0)));
endmodule

// File: rtl/ifft_butterfly.sv
// ifft_butterfly: 3-stage pipelined inverse DIT radix-2 butterfly; IFFT_BUTTERFLY_SAT_EN selects saturation over wrap
module ifft_butterfly #(
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int TW_W = fft_pkg::TW_W,
    parameter int SCALE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DATA_W-1:0]   in_a,
    input  logic [2*DATA_W-1:0]   in_b,
    input  logic signed [TW_W-1:0] w_real,
    input  logic signed [TW_W-1:0] w_imag,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   out_a,
    output logic [2*DATA_W-1:0]   out_b,
    output logic                  out_last,
    output logic                  ovf
);
    localparam int SW = DATA_W + 3;
    logic en, s1_valid, s1_last, s2_valid, s2_last, any_ovf;
    logic signed [DATA_W-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im, s2_a_re, s2_a_im;
    logic signed [TW_W-1:0] s1_w_re, s1_w_im;
    logic signed [DATA_W+1:0] t_re, t_im, s2_t_re, s2_t_im;
    logic [DATA_W:0] r_sre, r_sim, r_dre, r_dim;
    function automatic logic signed [SW-1:0] scl(input logic signed [SW-1:0] x);
        return SCALE != 0 ? (x + SW'(1)) >>> 1 : x;
    endfunction
    // returns {overflow, reduced component}
    function automatic logic [DATA_W:0] fit(input logic signed [SW-1:0] x);
        logic o;
        o = x[SW-1:DATA_W-1] != {(SW-DATA_W+1){x[SW-1]}};
`ifdef IFFT_BUTTERFLY_SAT_EN
        return {o, o ? {x[SW-1], {(DATA_W-1){~x[SW-1]}}} : x[DATA_W-1:0]};
`else
        return {o, x[DATA_W-1:0]};
`endif
    endfunction
    cmul_conj #(.DATA_W(DATA_W), .TW_W(TW_W), .SHIFT(fft_pkg::TW_SHIFT)) u_cmul (
        .b_re(s1_b_re),
        .b_im(s1_b_im),
        .w_re(s1_w_re),
        .w_im(s1_w_im),
        .t_re(t_re),
        .t_im(t_im)
    );
    assign r_sre = fit(scl(SW'(s2_a_re) + SW'(s2_t_re)));
    assign r_sim = fit(scl(SW'(s2_a_im) + SW'(s2_t_im)));
    assign r_dre = fit(scl(SW'(s2_a_re) - SW'(s2_t_re)));
    assign r_dim = fit(scl(SW'(s2_a_im) - SW'(s2_t_im)));
    assign any_ovf = r_sre[DATA_W] | r_sim[DATA_W] | r_dre[DATA_W] | r_dim[DATA_W];
    // one global enable: the whole pipe advances or the whole pipe holds
    assign in_ready = !rst && (!out_valid || out_ready);
    assign en = in_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last <= 1'b0;
            s2_valid <= 1'b0;
            s2_last <= 1'b0;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            ovf <= 1'b0;
            out_a <= '0;
            out_b <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_last <= in_last;
            s1_a_re <= in_a[2*DATA_W-1:DATA_W];
            s1_a_im <= in_a[DATA_W-1:0];
            s1_b_re <= in_b[2*DATA_W-1:DATA_W];
            s1_b_im <= in_b[DATA_W-1:0];
            s1_w_re <= w_real;
            s1_w_im <= w_imag;
            s2_valid <= s1_valid;
            s2_last <= s1_last;
            s2_a_re <= s1_a_re;
            s2_a_im <= s1_a_im;
            s2_t_re <= t_re;
            s2_t_im <= t_im;
            out_valid <= s2_valid;
            out_last <= s2_last;
            out_a <= {r_sre[DATA_W-1:0], r_sim[DATA_W-1:0]};
            out_b <= {r_dre[DATA_W-1:0], r_dim[DATA_W-1:0]};
            ovf <= ovf | (s2_valid & any_ovf);
        end
    end
endmodule

// File: tb/tb_ifft_butterfly.sv
// tb_ifft_butterfly: directed and random vectors against a scoreboard model of the butterfly
module tb_ifft_butterfly;
    logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 1;
    logic [31:0] in_a = 0, in_b = 0;
    logic signed [19:0] w_real = 0, w_imag = 0;
    logic in_ready, out_valid, out_last, ovf;
    logic [31:0] out_a, out_b;
    logic in_ready0, out_valid0, out_last0, ovf0;
    logic [31:0] out_a0, out_b0;
    logic [65:0] q[$];
    logic ovf_exp = 0;
    int n_vec = 0, n_err = 0;

    ifft_butterfly #(.SCALE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .w_real(w_real), .w_imag(w_imag), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_last(out_last), .ovf(ovf)
    );
    ifft_butterfly #(.SCALE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .w_real(w_real), .w_imag(w_imag), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready), .out_a(out_a0), .out_b(out_b0),
        .out_last(out_last0), .ovf(ovf0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int re, input int im);
        fft_pkg::cplx_t c;
        c.re = 16'(re);
        c.im = 16'(im);
        return c;
    endfunction

    // golden model for the SCALE=1 instance: {ovf, last, out_a, out_b}
    function automatic logic [65:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic signed [19:0] wr, input logic signed [19:0] wi,
                                          input logic last);
        longint ar = $signed(a[31:16]);
        longint ai = $signed(a[15:0]);
        longint br = $signed(b[31:16]);
        longint bi = $signed(b[15:0]);
        longint pr = br * wr + bi * wi;
        longint pi = bi * wr - br * wi;
        longint tr = (pr >>> 16) + ((pr >> 15) & 1);
        longint ti = (pi >>> 16) + ((pi >> 15) & 1);
        longint x[4];
        logic [15:0] r[4];
        bit o = 0;
        x[0] = ar + tr;
        x[1] = ai + ti;
        x[2] = ar - tr;
        x[3] = ai - ti;
        for (int k = 0; k < 4; k++) begin
            x[k] = (x[k] + 1) >>> 1;
            if (x[k] > 32767 || x[k] < -32768) begin
                o = 1;
`ifdef IFFT_BUTTERFLY_SAT_EN
                x[k] = x[k] > 0 ? 64'sd32767 : -64'sd32768;
`endif
            end
            r[k] = x[k][15:0];
        end
        return {o, last, r[0], r[1], r[2], r[3]};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            ovf_exp <= 0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("unexpected_out", 66'(out_a), 66'(0) - 1);
                else begin
                    check("sb_beat", {1'b0, out_last, out_a, out_b}, {1'b0, q[0][64:0]});
                    check("sb_ovf", 66'(ovf), 66'(ovf_exp | q[0][65]));
                    ovf_exp <= ovf_exp | q[0][65];
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_a, in_b, w_real, w_imag, in_last));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input int wr, input int wi, input logic last);
        in_a = a;
        in_b = b;
        w_real = 20'(wr);
        w_imag = 20'(wi);
        in_last = last;
        in_valid = 1;
        tick();
        in_valid = 0;
        in_last = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, cyc;
        logic acc;
        repeat (2) tick();
        check("rst_out_valid", 66'(out_valid), 0);
        check("rst_out_last", 66'(out_last), 0);
        check("rst_ovf", 66'(ovf), 0);
        check("rst_out_ab", {2'b0, out_a, out_b}, 0);
        rst = 0;
        #1;
        check("rst_in_ready", 66'(in_ready), 1);

        send(pack(100, 0), pack(50, 0), 65536, 0, 1);
        check("lat_c1", 66'(out_valid), 0);
        tick();
        check("lat_c2", 66'(out_valid), 0);
        tick();
        check("dir1_valid", 66'(out_valid), 1);
        check("dir1_a", 66'(out_a), 66'(pack(75, 0)));
        check("dir1_b", 66'(out_b), 66'(pack(25, 0)));
        check("dir1_last", 66'(out_last), 1);
        tick();

        send(pack(100, 0), pack(50, 0), 0, 65536, 0);
        repeat (2) tick();
        check("dir2_a", 66'(out_a), 66'(pack(50, -25)));
        check("dir2_b", 66'(out_b), 66'(pack(50, 25)));
        tick();

        send(pack(32767, 0), pack(32767, 0), 65536, 0, 0);
        repeat (2) tick();
`ifdef IFFT_BUTTERFLY_SAT_EN
        check("ovf_a", 66'(out_a0), 66'(pack(32767, 0)));
`else
        check("ovf_a", 66'(out_a0), 66'(pack(-2, 0)));
`endif
        check("ovf_b", 66'(out_b0), 66'(pack(0, 0)));
        check("ovf_set", 66'(ovf0), 1);
        check("ovf_scaled_clear", 66'(ovf), 0);
        tick();
        send(pack(0, 0), pack(1, -1), 32768, 0, 0);
        repeat (2) tick();
        check("round_a", 66'(out_a0), 66'(pack(1, 0)));
        check("round_b", 66'(out_b0), 66'(pack(-1, 0)));
        check("ovf_sticky", 66'(ovf0), 1);
        tick();

        sent = 0;
        cyc = 0;
        while (sent < 8 && cyc < 50) begin
            in_valid = 1;
            in_a = pack(10 * sent, -sent);
            in_b = pack(sent * 7, 2);
            w_real = 20'(65536 - 1000 * sent);
            w_imag = 20'(300 * sent);
            in_last = sent == 7;
            out_ready = !(cyc >= 3 && cyc <= 5);
            #1;
            if (cyc <= 6) check("stall_in_ready", 66'(in_ready), 66'(!(cyc >= 3 && cyc <= 5)));
            acc = in_ready;
            tick();
            if (acc) sent++;
            cyc++;
        end
        check("stall_sent", 66'(sent), 8);
        in_valid = 0;
        in_last = 0;
        out_ready = 1;
        repeat (6) tick();
        check("stall_drain", 66'(q.size()), 0);

        send(pack(1000, 5), pack(200, 3), 40000, 0, 0);
        send(pack(2000, 6), pack(300, 4), 0, 40000, 1);
        rst = 1;
        in_valid = 1;
        in_a = pack(7, 7);
        in_b = pack(7, 7);
        tick();
        check("rst_mid_valid", 66'(out_valid), 0);
        check("rst_mid_ovf0", 66'(ovf0), 0);
        rst = 0;
        in_valid = 0;
        #1;
        check("rst_mid_ready", 66'(in_ready), 1);
        repeat (5) tick();
        check("rst_flush", 66'(out_valid), 0);

        for (int i = 0; i < 300; i++) begin
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            in_a = $urandom;
            in_b = i % 5 == 0 ? pack(i % 2 == 0 ? 1 : -1, i % 3 == 0 ? -1 : 1) : $urandom;
            w_real = i % 5 == 0 ? 20'sd32768 : 20'(int'($urandom_range(0, 131072)) - 65536);
            w_imag = i % 5 == 0 ? -20'sd32768 : 20'(int'($urandom_range(0, 131072)) - 65536);
            in_last = $urandom_range(0, 7) == 0;
            tick();
        end
        in_valid = 0;
        out_ready = 1;
        repeat (6) tick();
        check("rand_drain", 66'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ifft_butterfly.md
IFFT_BUTTERFLY -- requirements
Module: ifft_butterfly

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the width of each real/imag component (packed word = 2*DATA_W, real in upper half, imag in lower half).
REQ-002 SHALL have parameter TW_W, default 20, meaning the signed twiddle component width, with 1.0 = 2^16.
REQ-003 SHALL have parameter SCALE, default 1, meaning halve both outputs with rounding (1/N normalisation per stage); 0 = no scaling.
REQ-004 SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_a  in  2*DATA_W  complex A.
- in_b  in  2*DATA_W  complex B.
- w_real  in  TW_W  signed twiddle, real part.
- w_imag  in  TW_W  signed twiddle, imag part.
- in_last  in  1  final beat of a frame.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_a  out  2*DATA_W  A + T result.
- out_b  out  2*DATA_W  A - T result.
- out_last  out  1  in_last delayed with its beat.
- ovf  out  1  sticky overflow flag.
REQ-005 SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-006 SHALL compute the inverse DIT butterfly T = B*conj(W): Pr = Br*Wr + Bi*Wi; Pi = Bi*Wr - Br*Wi, at full precision (DATA_W+TW_W+1 bits).
REQ-007 SHALL round T as Tr = (Pr >>> 16) + Pr[15] (Ti likewise), held in DATA_W+2 bits.
REQ-008 SHALL form S = A+T and D = A-T in DATA_W+3 bits; if SCALE=1, each component becomes (x+1) >>> 1.
REQ-009 SHALL reduce each component to DATA_W bits per REQ-017 and set ovf when any component is out of range.
REQ-010 SHALL be a 3-stage pipeline: S1 registers the inputs, S2 the multiply/round, S3 the add/sub/scale; latency 3 cycles with out_ready held high.
REQ-011 SHALL transfer a beat when valid && ready, on both sides.
REQ-012 SHALL drive in_ready = !s3_valid || out_ready, as a global stall enable; all stages SHALL hold when it is low, and no beat SHALL be lost or duplicated.
REQ-013 SHALL sustain 1 beat/cycle under continuous valid and ready, and SHALL keep a bubble as a bubble, with no reordering.
REQ-014 SHALL carry out_last with its beat; ovf SHALL remain 1 until rst.

Reset
REQ-015 SHALL clear on rst all stage valids, out_valid, out_last and ovf, and SHALL set out_a = out_b = 0; in_ready SHALL be 1 in the cycle after reset.
REQ-016 SHALL discard in-flight beats when rst is asserted mid-operation; a beat presented during rst SHALL NOT be accepted.

Configuration
REQ-017 SHALL honour macro IFFT_BUTTERFLY_SAT_EN: when defined, out-of-range components saturate to +(2^(DATA_W-1)-1) or -2^(DATA_W-1); when undefined, they wrap (two's-complement truncation). ovf SHALL be set in both builds.

Structure
REQ-018 SHALL take DATA_W, TW_W, the Q16 twiddle shift (16), and the packed-complex typedef (real/imag fields) from the shared package fft_pkg.
REQ-019 SHALL instantiate one sub-module, cmul_conj (the complex multiply by conj(W) with rounding, S2); everything else SHALL be inline.

Verification
REQ-020 SHALL cover, with SCALE=1: A=(100,0), B=(50,0), W=(65536,0) -> out_a=(75,0), out_b=(25,0), after 3 cycles.
REQ-021 SHALL cover, with SCALE=1: A=(100,0), B=(50,0), W=(0,65536) -> out_a=(50,-25), out_b=(50,25).
REQ-022 SHALL cover, with SCALE=0: A=(32767,0), B=(32767,0), W=(65536,0) -> out_a.re=32767 with SAT_EN (or -2 without), ovf=1 and sticky.
REQ-023 SHALL cover 8 back-to-back beats with out_ready low for cycles 3-5 -> in_ready low while S3 is stalled, all 8 outputs in order, out_last only on beat 8.
REQ-024 SHALL cover rst pulsed while 2 beats are in flight -> out_valid=0 next cycle, and those beats are never emitted.
REQ-025 SHALL cover random vectors against a golden model -> bit-exact match, including the rounding at Pr[15]=1 boundaries.
